// File: rtl/mshr_evict_burst_seq.sv
// Eviction burst sequencer: queues MSHR eviction requests and replays each one
// as a BEATS-long read burst, wrapping from the critical beat when WRAP_MODE=1.
module mshr_evict_burst_seq #(
    parameter int TAG_W     = 20,
    parameter int WAY_W     = 2,
    parameter int IDX_W     = 6,
    parameter int OFF_W     = 4,
    parameter int BEATS     = 4,
    parameter int DEPTH     = 2,
    parameter int WRAP_MODE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         evict_req_vld_mshr,
    output logic                         evict_req_rdy_mshr,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic [WAY_W-1:0]             in_way,
    input  logic [IDX_W-1:0]             in_index,
    input  logic [OFF_W-1:0]             in_offset,
    input  logic                         evict_en,
    output logic                         evict_req_vld,
    input  logic                         evict_req_rdy,
    output logic [TAG_W-1:0]             out_tag,
    output logic [WAY_W-1:0]             out_way,
    output logic [IDX_W-1:0]             out_index,
    output logic [OFF_W-1:0]             out_offset,
    output logic                         rd_first,
    output logic                         rd_last,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   q_cnt
);

    localparam int L     = $clog2(BEATS);
    localparam int ENT_W = TAG_W + WAY_W + IDX_W + OFF_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [OFF_W-1:0] LOW_MASK = OFF_W'(BEATS - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q;
    logic [WAY_W-1:0]   way_q;
    logic [IDX_W-1:0]   idx_q;
    logic [OFF_W-1:0]   off_q;
    logic [L-1:0]       b_q, b_d, beat_lo;
    logic [ENT_W-1:0]   head;
    logic               push, pop, beat_hs, last_beat, q_nempty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready depends only on registered occupancy, never on the incoming valid.
    assign evict_req_rdy_mshr = cnt_q < CNT_W'(DEPTH);
    assign push      = evict_req_vld_mshr && evict_req_rdy_mshr;
    assign q_nempty  = cnt_q != '0;
    assign head      = mem_q[rd_ptr_q];
    assign beat_hs   = (state_q == BURST) && evict_req_rdy;
    assign last_beat = b_q == L'(BEATS - 1);

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (q_nempty && evict_en) begin
                    pop     = 1'b1;
                    state_d = BURST;
                    b_d     = '0;
                end
            end
            BURST: begin
                if (beat_hs) begin
                    b_d = b_q + L'(1);
                    if (last_beat) begin
                        b_d = '0;
                        if (q_nempty && evict_en) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_tag, in_way, in_index, in_offset};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            way_q    <= '0;
            idx_q    <= '0;
            off_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
                {tag_q, way_q, idx_q, off_q} <= head;
            end
        end
    end

    // Low offset bits walk modulo BEATS from the start beat; upper bits stay put.
    assign beat_lo = ((WRAP_MODE != 0) ? off_q[L-1:0] : L'(0)) + b_q;

    assign evict_req_vld = (state_q == BURST);
    assign out_tag       = evict_req_vld ? tag_q : '0;
    assign out_way       = evict_req_vld ? way_q : '0;
    assign out_index     = evict_req_vld ? idx_q : '0;
    assign out_offset    = evict_req_vld ? ((off_q & ~LOW_MASK) | OFF_W'(beat_lo)) : '0;
    assign rd_first      = evict_req_vld && (b_q == '0);
    assign rd_last       = evict_req_vld && last_beat;
    assign busy          = evict_req_vld || q_nempty;
    assign q_cnt         = cnt_q;

endmodule

// File: tb/tb_mshr_evict_burst_seq.sv
// Scoreboard bench for mshr_evict_burst_seq: directed requests push expected
// beats; per-DUT monitors compare every presented beat against the queue head.
module tb_mshr_evict_burst_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // dut0: defaults (WRAP_MODE=1)
    logic vm0, rm0, en0, v0, r0, f0, l0, busy0;
    logic [19:0] itag0, otag0;
    logic [1:0]  iway0, oway0, qc0;
    logic [5:0]  iidx0, oidx0;
    logic [3:0]  ioff0, ooff0;
    // dut1: WRAP_MODE=0
    logic vm1, rm1, en1, v1, r1, f1, l1, busy1;
    logic [19:0] itag1, otag1;
    logic [1:0]  iway1, oway1, qc1;
    logic [5:0]  iidx1, oidx1;
    logic [3:0]  ioff1, ooff1;

    mshr_evict_burst_seq dut0 (
        .clk(clk), .rst_n(rst_n),
        .evict_req_vld_mshr(vm0), .evict_req_rdy_mshr(rm0),
        .in_tag(itag0), .in_way(iway0), .in_index(iidx0), .in_offset(ioff0),
        .evict_en(en0), .evict_req_vld(v0), .evict_req_rdy(r0),
        .out_tag(otag0), .out_way(oway0), .out_index(oidx0), .out_offset(ooff0),
        .rd_first(f0), .rd_last(l0), .busy(busy0), .q_cnt(qc0)
    );

    mshr_evict_burst_seq #(.WRAP_MODE(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .evict_req_vld_mshr(vm1), .evict_req_rdy_mshr(rm1),
        .in_tag(itag1), .in_way(iway1), .in_index(iidx1), .in_offset(ioff1),
        .evict_en(en1), .evict_req_vld(v1), .evict_req_rdy(r1),
        .out_tag(otag1), .out_way(oway1), .out_index(oidx1), .out_offset(ooff1),
        .rd_first(f1), .rd_last(l1), .busy(busy1), .q_cnt(qc1)
    );

    typedef struct packed {
        logic [19:0] tag;
        logic [1:0]  way;
        logic [5:0]  idx;
        logic [3:0]  off;
        logic        first;
        logic        last;
    } beat_t;

    beat_t exp0[$];
    beat_t exp1[$];
    int checks = 0;
    int fails = 0;
    int hs_cnt = 0;
    int run = 0;
    int last_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // offs holds the four hand-computed beat offsets, first beat in [15:12].
    task automatic push_burst(input bit sel, input logic [19:0] tag, input logic [1:0] way,
                              input logic [5:0] idx, input logic [15:0] offs);
        for (int i = 0; i < 4; i++) begin
            beat_t e;
            e.tag   = tag;
            e.way   = way;
            e.idx   = idx;
            e.off   = offs[15-4*i -: 4];
            e.first = (i == 0);
            e.last  = (i == 3);
            if (sel) exp1.push_back(e);
            else     exp0.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [19:0] tag, input logic [1:0] way,
                         input logic [5:0] idx, input logic [3:0] off);
        bit acc;
        acc   = 1'b0;
        vm0   = 1'b1;
        itag0 = tag;
        iway0 = way;
        iidx0 = idx;
        ioff0 = off;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = rm0;
            tick();
        end
        vm0 = 1'b0;
        if (!acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle0();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (!busy0 && !v0) done = 1'b1;
        end
        if (!done) check("idle_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic wait_hs(input int target);
        for (int n = 0; n < 100 && hs_cnt < target; n++) begin
            @(negedge clk);
            #1;
        end
        if (hs_cnt < target) check("hs_timeout", 64'(hs_cnt), 64'(target));
    endtask

    always @(negedge clk) begin
        beat_t a;
        if (rst_n) begin
            a = {otag0, oway0, oidx0, ooff0, f0, l0};
            if (v0) begin
                if (exp0.size() == 0) begin
                    check("unexpected_beat0", 64'(a), 64'd0);
                end else begin
                    check("beat0", 64'(a), 64'(exp0[0]));
                    if (r0) void'(exp0.pop_front());
                end
                if (r0) begin
                    hs_cnt++;
                    run++;
                end
            end else begin
                check("idle_payload0", 64'(a), 64'd0);
                if (run != 0) last_run = run;
                run = 0;
            end
        end
    end

    always @(negedge clk) begin
        beat_t a;
        if (rst_n) begin
            a = {otag1, oway1, oidx1, ooff1, f1, l1};
            if (v1) begin
                if (exp1.size() == 0) begin
                    check("unexpected_beat1", 64'(a), 64'd0);
                end else begin
                    check("beat1", 64'(a), 64'(exp1[0]));
                    if (r1) void'(exp1.pop_front());
                end
            end else begin
                check("idle_payload1", 64'(a), 64'd0);
            end
        end
    end

    initial begin
        int base;
        rst_n = 1'b0;
        vm0 = 0; itag0 = '0; iway0 = '0; iidx0 = '0; ioff0 = '0; en0 = 1; r0 = 1;
        vm1 = 0; itag1 = '0; iway1 = '0; iidx1 = '0; ioff1 = '0; en1 = 1; r1 = 1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld", 64'(v0), 64'd0);
        check("rst_qcnt", 64'(qc0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_first_last", 64'({f0, l0}), 64'd0);
        check("rst_payload", 64'({otag0, oway0, oidx0, ooff0}), 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_release", 64'(rm0), 64'd1);
        tick();

        // critical-beat-first wrap from offset 6
        push_burst(0, 20'hABCDE, 2'd1, 6'h2A, 16'h6745);
        send0(20'hABCDE, 2'd1, 6'h2A, 4'h6);
        wait_idle0();
        check("wrap_run_len", 64'(last_run), 64'd4);

        // line-aligned start on the WRAP_MODE=0 instance
        push_burst(1, 20'h12345, 2'd2, 6'h11, 16'h4567);
        vm1 = 1'b1; itag1 = 20'h12345; iway1 = 2'd2; iidx1 = 6'h11; ioff1 = 4'h6;
        @(negedge clk);
        check("dut1_rdy", 64'(rm1), 64'd1);
        tick();
        vm1 = 1'b0;
        repeat (8) @(negedge clk);
        check("dut1_drained", 64'(exp1.size()), 64'd0);
        tick();

        // three back-to-back requests, zero-bubble chaining
        base = hs_cnt;
        push_burst(0, 20'h00001, 2'd0, 6'h01, 16'h0123);
        push_burst(0, 20'h00002, 2'd3, 6'h02, 16'hB89A);
        push_burst(0, 20'h00003, 2'd2, 6'h3F, 16'hFCDE);
        send0(20'h00001, 2'd0, 6'h01, 4'h0);
        send0(20'h00002, 2'd3, 6'h02, 4'hB);
        send0(20'h00003, 2'd2, 6'h3F, 4'hF);
        wait_idle0();
        check("b2b_run_len", 64'(last_run), 64'd12);
        check("b2b_beats", 64'(hs_cnt - base), 64'd12);

        // backpressure held for 3 cycles on beat 2
        base = hs_cnt;
        push_burst(0, 20'hFACE0, 2'd1, 6'h05, 16'h3012);
        send0(20'hFACE0, 2'd1, 6'h05, 4'h3);
        wait_hs(base + 2);
        tick();
        r0 = 1'b0;
        repeat (3) tick();
        r0 = 1'b1;
        wait_idle0();
        check("stall_beats", 64'(hs_cnt - base), 64'd4);

        // evict_en gating: queue fills, nothing starts until enabled
        en0 = 1'b0;
        push_burst(0, 20'h0BEEF, 2'd2, 6'h20, 16'h89AB);
        push_burst(0, 20'h0CAFE, 2'd3, 6'h21, 16'h5674);
        send0(20'h0BEEF, 2'd2, 6'h20, 4'h8);
        send0(20'h0CAFE, 2'd3, 6'h21, 4'h5);
        repeat (3) @(negedge clk);
        check("full_rdy_low", 64'(rm0), 64'd0);
        check("full_qcnt", 64'(qc0), 64'd2);
        check("gated_no_vld", 64'(v0), 64'd0);
        tick();
        en0 = 1'b1;
        @(negedge clk);
        check("en_same_cycle_vld", 64'(v0), 64'd0);
        @(negedge clk);
        check("en_next_cycle_vld", 64'(v0), 64'd1);
        tick();
        en0 = 1'b0;
        repeat (8) @(negedge clk);
        check("en_drop_run_len", 64'(last_run), 64'd4);
        check("en_drop_no_vld", 64'(v0), 64'd0);
        check("en_drop_qcnt", 64'(qc0), 64'd1);
        tick();
        en0 = 1'b1;
        wait_idle0();
        check("en_all_drained", 64'(exp0.size()), 64'd0);

        // reset mid-burst with one request still queued
        base = hs_cnt;
        push_burst(0, 20'h55555, 2'd0, 6'h0A, 16'h2301);
        send0(20'h55555, 2'd0, 6'h0A, 4'h2);
        send0(20'h66666, 2'd1, 6'h0B, 4'h9);
        wait_hs(base + 2);
        tick();
        rst_n = 1'b0;
        exp0.delete();
        #1;
        check("midrst_vld", 64'(v0), 64'd0);
        check("midrst_qcnt", 64'(qc0), 64'd0);
        check("midrst_busy", 64'(busy0), 64'd0);
        check("midrst_payload", 64'({otag0, oway0, oidx0, ooff0, f0, l0}), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_no_vld", 64'(v0), 64'd0);
        check("post_rst_qcnt", 64'(qc0), 64'd0);
        check("post_rst_rdy", 64'(rm0), 64'd1);

        check("exp0_empty", 64'(exp0.size()), 64'd0);
        check("exp1_empty", 64'(exp1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
